// File: rtl/manchester_tx_scheduler.sv
// -----------------------------------------------------------------------------
// manchester_tx_scheduler
//
// Round-robin transmit scheduler in front of a single Manchester encoder.
// Everything runs in the encoder's 2x bit clock domain.
//
// Frame flow: IDLE -> LOAD -> WAIT_START -> WAIT_END -> GAP -> IDLE
//   IDLE        arbitrate among requesters (only while the encoder is idle)
//   LOAD        one-cycle write strobe with the latched word
//   WAIT_START  wait for enc_busy_i to rise, bounded by START_TO cycles
//   WAIT_END    wait for enc_busy_i to fall, then ack and count the frame
//   GAP         enforced idle time before the next arbitration
//
// Handshake: req_i[i] is a level request held until the matching one-cycle
// ack_o[i] pulse; req_data_i word i is stable while req_i[i] is high. grant_o
// is one-hot from arbitration until (and cleared with) the ack. A request that
// drops while granted does not cancel the frame: the latched word is still
// sent and acked.
//
// Ports
//   clk2x_i      sole clock (encoder 2x bit clock)
//   rst_i        asynchronous, active-high reset
//   req_i        per-requester level request
//   req_data_i   word i at [i*SEQ_LENGTH +: SEQ_LENGTH]
//   grant_o      one-hot grant, held until ack
//   ack_o        one-cycle pulse: frame done or abandoned
//   enc_wrn_o    registered one-cycle write strobe to the encoder
//   enc_din_o    registered word to the encoder, valid with enc_wrn_o
//   enc_busy_i   encoder dout_on
//   busy_o       high in every state except IDLE
//   err_o        one-cycle pulse when the encoder never starts
//   frame_cnt_o  completed frames, wraps; abandoned frames are not counted
//   dbg_state_o  current FSM state encoding
// -----------------------------------------------------------------------------
module manchester_tx_scheduler #(
  parameter int SEQ_LENGTH = 8,
  parameter int NUM_REQ    = 2,
  parameter int GAP_CYCLES = 4,
  parameter int START_TO   = 8
) (
  input  logic                          clk2x_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*SEQ_LENGTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic [NUM_REQ-1:0]            ack_o,
  output logic                          enc_wrn_o,
  output logic [SEQ_LENGTH-1:0]         enc_din_o,
  input  logic                          enc_busy_i,
  output logic                          busy_o,
  output logic                          err_o,
  output logic [15:0]                   frame_cnt_o,
  output logic [2:0]                    dbg_state_o
);

  localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_MAX = (START_TO > GAP_CYCLES) ? START_TO : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LOAD       = 3'd1,
    S_WAIT_START = 3'd2,
    S_WAIT_END   = 3'd3,
    S_GAP        = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d;
  logic [NUM_REQ-1:0]      ack_q, ack_d;
  logic                    wrn_q, wrn_d;
  logic [SEQ_LENGTH-1:0]   din_q, din_d;
  logic                    err_q, err_d;
  logic [15:0]             frame_cnt_q, frame_cnt_d;

  // Round-robin pick: first set request at or after ptr_q+1, wrapping.
  logic                    arb_found;
  logic [PTR_W-1:0]        arb_idx;

  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!arb_found && req_i[(int'(ptr_q) + k) % NUM_REQ]) begin
        arb_found = 1'b1;
        arb_idx   = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    ack_d       = '0;
    wrn_d       = 1'b0;
    din_d       = din_q;
    err_d       = 1'b0;
    frame_cnt_d = frame_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        // A busy encoder blocks arbitration, which also covers a frame that
        // was still being shifted out when we came out of reset.
        if (arb_found && !enc_busy_i) begin
          grant_d = NUM_REQ'(1) << arb_idx;
          din_d   = req_data_i[int'(arb_idx)*SEQ_LENGTH +: SEQ_LENGTH];
          ptr_d   = arb_idx;
          wrn_d   = 1'b1;  // strobe is high for exactly the LOAD cycle
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        cnt_d   = CNT_W'(START_TO);
        state_d = S_WAIT_START;
      end

      S_WAIT_START: begin
        if (enc_busy_i) begin
          state_d = S_WAIT_END;
        end else if (cnt_q == CNT_W'(1)) begin
          // Encoder never started: abandon the word, release the requester.
          err_d   = 1'b1;
          ack_d   = grant_q;
          grant_d = '0;
          cnt_d   = CNT_W'(GAP_CYCLES);
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_WAIT_END: begin
        if (!enc_busy_i) begin
          ack_d       = grant_q;
          grant_d     = '0;
          frame_cnt_d = frame_cnt_q + 16'd1;
          cnt_d       = CNT_W'(GAP_CYCLES);
          state_d     = S_GAP;
        end
      end

      S_GAP: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk2x_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      ptr_q       <= PTR_W'(NUM_REQ - 1);  // requester 0 wins first
      cnt_q       <= '0;
      grant_q     <= '0;
      ack_q       <= '0;
      wrn_q       <= 1'b0;
      din_q       <= '0;
      err_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      ack_q       <= ack_d;
      wrn_q       <= wrn_d;
      din_q       <= din_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign grant_o     = grant_q;
  assign ack_o       = ack_q;
  assign enc_wrn_o   = wrn_q;
  assign enc_din_o   = din_q;
  assign err_o       = err_q;
  assign frame_cnt_o = frame_cnt_q;
  assign busy_o      = (state_q != S_IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_manchester_tx_scheduler.sv
module tb_manchester_tx_scheduler;

  localparam int SL = 8;
  localparam int NR = 2;
  localparam int G  = 4;
  localparam int ST = 8;
  localparam int ENC_LEN = 2 * SL;  // encoder busy cycles per word

  // ---------------- clock / reset ----------------
  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req;
  logic [NR*SL-1:0] req_data;
  logic [NR-1:0]   grant, ack;
  logic            enc_wrn;
  logic [SL-1:0]   enc_din;
  logic            enc_busy;
  logic            busy, err;
  logic [15:0]     frame_cnt;
  logic [2:0]      dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  manchester_tx_scheduler #(
    .SEQ_LENGTH(SL), .NUM_REQ(NR), .GAP_CYCLES(G), .START_TO(ST)
  ) dut (
    .clk2x_i(clk), .rst_i(rst), .req_i(req), .req_data_i(req_data),
    .grant_o(grant), .ack_o(ack), .enc_wrn_o(enc_wrn), .enc_din_o(enc_din),
    .enc_busy_i(enc_busy), .busy_o(busy), .err_o(err),
    .frame_cnt_o(frame_cnt), .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [SL-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- encoder model ----------------
  // busy rises 3 cycles after the strobe cycle and stays high ENC_LEN cycles.
  logic enc_en = 1'b1;
  initial begin
    enc_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (enc_wrn && enc_en) begin
        repeat (3) @(posedge clk);
        #1 enc_busy = 1'b1;
        repeat (ENC_LEN) @(posedge clk);
        #1 enc_busy = 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  int   wrn_cnt   = 0;
  int   fall_cyc  = -1000;
  logic prev_busy = 1'b0;
  logic gap_armed = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      gap_armed = 1'b0;
    end else begin
      if (enc_wrn) begin
        wrn_cnt++;
        check("wrn_busy_low", enc_busy, 0);
        if (gap_armed) check("wrn_gap", (cyc - fall_cyc) >= (G + 2), 1);
        check("wrn_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("din", enc_din, exp_q.pop_front());
        gap_armed = 1'b0;
      end
      if (ack != '0) begin
        gap_armed = 1'b1;
        check("ack_onehot", $onehot(ack), 1);
      end
      if (prev_busy && !enc_busy) fall_cyc = cyc;
    end
    prev_busy = enc_busy;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_wrn(input string tag, input logic [NR-1:0] exp_grant, output int c);
    c = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (enc_wrn) break;
    end
    check({tag, "_seen"}, enc_wrn, 1);
    check({tag, "_grant"}, grant, exp_grant);
    c = cyc;
    @(negedge clk);
    check({tag, "_wrn_pulse"}, enc_wrn, 0);
  endtask

  task automatic wait_ack(input string tag, input logic [NR-1:0] exp_ack,
                          input logic [NR-1:0] req_after, output int c, output logic e);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ack != '0) break;
    end
    check(tag, ack, exp_ack);
    check({tag, "_grant_clr"}, grant, 0);
    c   = cyc;
    e   = err;
    req = req_after;
    @(negedge clk);
    check({tag, "_pulse"}, ack, 0);
  endtask

  // ---------------- directed tests ----------------
  int   w, a, f, snap;
  logic e;

  initial begin
    rst = 1'b1; req = '0; req_data = '0;
    repeat (3) @(negedge clk);
    check("rst_grant", grant, 0);
    check("rst_ack", ack, 0);
    check("rst_wrn", enc_wrn, 0);
    check("rst_din", enc_din, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_cnt", frame_cnt, 0);
    rst = 1'b0;

    // T1: single frame from requester 0
    req_data[7:0] = 8'hA5; exp_q.push_back(8'hA5); req = 2'b01;
    wait_wrn("t1", 2'b01, w);
    wait_ack("t1_ack", 2'b01, 2'b00, a, e);
    check("t1_ack_after_fall", a - fall_cyc, 1);
    check("t1_frame_lat", a - w, 3 + ENC_LEN + 1);
    check("t1_err", e, 0);
    check("t1_cnt", frame_cnt, 1);

    // T2: both held from reset: 0,1,0,1
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    req_data = {8'hC3, 8'h3C};
    exp_q.push_back(8'h3C); exp_q.push_back(8'hC3);
    exp_q.push_back(8'h3C); exp_q.push_back(8'hC3);
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_wrn($sformatf("t2_%0d", i), (i % 2 == 0) ? 2'b01 : 2'b10, w);
      wait_ack($sformatf("t2_ack%0d", i), (i % 2 == 0) ? 2'b01 : 2'b10,
               (i == 3) ? 2'b00 : 2'b11, a, e);
    end
    check("t2_cnt", frame_cnt, 4);

    // T3: encoder never starts
    enc_en = 1'b0;
    req_data[15:8] = 8'h5A; exp_q.push_back(8'h5A); req = 2'b10;
    wait_wrn("t3", 2'b10, w);
    wait_ack("t3_ack", 2'b10, 2'b11, a, e);
    check("t3_err", e, 1);
    check("t3_err_lat", a - w, 1 + ST);
    check("t3_err_pulse", err, 0);
    check("t3_cnt", frame_cnt, 4);
    enc_en = 1'b1;
    exp_q.push_back(8'h3C);
    wait_wrn("t3_rr", 2'b01, w);
    wait_ack("t3_rr_ack", 2'b01, 2'b00, a, e);
    check("t3_cnt2", frame_cnt, 5);

    // T4: reset during WAIT_END
    req_data[7:0] = 8'h77; exp_q.push_back(8'h77); exp_q.push_back(8'h77);
    req = 2'b01;
    wait_wrn("t4", 2'b01, w);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (enc_busy) break;
    end
    @(negedge clk);
    snap = wrn_cnt;
    rst = 1'b1;
    #1;
    check("t4_grant", grant, 0);
    check("t4_ack", ack, 0);
    check("t4_busy", busy, 0);
    check("t4_err", err, 0);
    check("t4_cnt", frame_cnt, 0);
    check("t4_din", enc_din, 0);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!enc_busy) break;
    end
    f = cyc;
    check("t4_busy_fell", enc_busy, 0);
    check("t4_no_wrn_while_busy", wrn_cnt, snap);
    wait_wrn("t4_re", 2'b01, w);
    check("t4_wrn_after_fall", w - f, 1);
    wait_ack("t4_ack2", 2'b01, 2'b00, a, e);
    check("t4_cnt2", frame_cnt, 1);

    // T5: req0 dropped right after grant
    req_data[7:0] = 8'hE1; exp_q.push_back(8'hE1); req = 2'b01;
    wait_wrn("t5", 2'b01, w);
    req = 2'b00;
    wait_ack("t5_ack", 2'b01, 2'b00, a, e);
    check("t5_cnt", frame_cnt, 2);
    snap = wrn_cnt;
    repeat (30) @(negedge clk);
    check("t5_no_extra_wrn", wrn_cnt, snap);

    // T6: frame counter wrap
    force dut.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_q;
    @(negedge clk);
    check("t6_preload", frame_cnt, 16'hFFFF);
    req_data[15:8] = 8'h96; exp_q.push_back(8'h96); req = 2'b10;
    wait_wrn("t6", 2'b10, w);
    wait_ack("t6_ack", 2'b10, 2'b00, a, e);
    check("t6_err", e, 0);
    check("t6_cnt_wrap", frame_cnt, 0);

    repeat (5) @(negedge clk);
    check("exp_q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
